// File: rtl/data_memory_mc.sv
// Multi-cycle byte-addressable data memory with a Req/Ready handshake, programmable
// wait states, big-endian sub-word lanes and misaligned/out-of-range rejection.
module data_memory_mc #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Ready,
    output logic                  Error,
    output logic [DATA_WIDTH-1:0] DataRead
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                  state;
    logic [3:0]              count;
    logic                    cap_write;
    logic                    cap_unsigned;
    logic [1:0]              cap_size;
    logic [1:0]              cap_off;
    logic [DEPTH_LOG2-1:0]   cap_index;
    logic [DATA_WIDTH-1:0]   cap_wdata;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req_error;
    logic                    commit;
    logic [4:0]              shamt;
    logic [DATA_WIDTH-1:0]   lane_mask;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   merged;
    logic [DATA_WIDTH-1:0]   lane;
    logic [DATA_WIDTH-1:0]   load_value;

    // Rejection is decided from the live inputs at accept time, so a bad access never enters WAIT.
    always_comb begin
        req_error = 1'b0;
        case (Size)
            SZ_RSVD: req_error = 1'b1;
            SZ_HALF: req_error = Addr[0];
            SZ_WORD: req_error = (Addr[1:0] != 2'b00);
            default: req_error = 1'b0;
        endcase
        if ((Addr >> (DEPTH_LOG2 + 2)) != '0)
            req_error = 1'b1;
    end

    // Big-endian lanes: offset 0 is the most significant byte, hence the inverted offset.
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        case (cap_size)
            SZ_BYTE: begin
                shamt     = {~cap_off, 3'b000};
                lane_mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                shamt     = {~cap_off[1], 4'b0000};
                lane_mask = 32'h0000_FFFF;
            end
            default: ;
        endcase

        rd_word = mem[cap_index];
        merged  = (rd_word & ~(lane_mask << shamt)) | ((cap_wdata & lane_mask) << shamt);
        lane    = (rd_word >> shamt) & lane_mask;

        load_value = lane;
        case (cap_size)
            SZ_BYTE: if (!cap_unsigned) load_value = {{24{lane[7]}}, lane[7:0]};
            SZ_HALF: if (!cap_unsigned) load_value = {{16{lane[15]}}, lane[15:0]};
            default: ;
        endcase
    end

    assign Busy   = (state == S_WAIT);
    assign commit = (state == S_WAIT) && (count == 4'd0) && !Rst;

    // NOTE: the array has no reset branch; clearing it would forbid RAM inference and the
    // contents are defined only by stores.
    always_ff @(posedge Clk) begin
        if (commit && cap_write)
            mem[cap_index] <= merged;
    end

    // NOTE: all state here uses <= so every register samples pre-edge values of its peers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            count    <= 4'd0;
            Ready    <= 1'b0;
            Error    <= 1'b0;
            DataRead <= '0;
        end else begin
            Ready <= 1'b0;
            Error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Req) begin
                        cap_write    <= MemWrite;
                        cap_size     <= Size;
                        cap_unsigned <= Unsigned;
                        cap_off      <= Addr[1:0];
                        cap_index    <= Addr[DEPTH_LOG2+1:2];
                        cap_wdata    <= WriteData;
                        if (req_error) begin
                            Ready    <= 1'b1;
                            Error    <= 1'b1;
                            DataRead <= '0;
                        end else begin
                            state <= S_WAIT;
                            count <= 4'(WAIT_STATES);
                        end
                    end
                end
                S_WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (!cap_write)
                            DataRead <= load_value;
                        Ready <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
